hack_instr_decode: RTL and testbench

- Instruction decoder for the Hack CPU. It splits one DW-bit instruction word into the instruction type, the A-instruction value, and the individual C-instruction control bits (a, c1..c6, d1..d3, j1..j3).
- It sits between instruction memory/fetch and the ALU, register-load and jump logic.
- Outputs are registered: one clock cycle of latency, with a hold enable.

---
 rtl/hack_instr_decode_pkg.sv | 38 +++
 rtl/hack_instr_decode_if.sv | 40 ++++
 rtl/hack_instr_decode_fields.sv | 29 ++
 rtl/hack_instr_decode.sv | 94 +++++++++
 tb/tb_hack_instr_decode.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/hack_instr_decode_pkg.sv
// Shared definitions for the Hack instruction decoder: word width, field
// bit positions, instruction-type enum, control-bit bundle and the
// don't-care check used by the optional illegal-instruction detector.
package hack_pkg;

    localparam int INSTR_W  = 16;

    localparam int TYPE_BIT = 15;
    localparam int DC_MSB   = 14;
    localparam int DC_LSB   = 13;
    localparam int A_BIT    = 12;
    localparam int C_MSB    = 11;
    localparam int C_LSB    = 6;
    localparam int D_MSB    = 5;
    localparam int D_LSB    = 3;
    localparam int J_MSB    = 2;
    localparam int J_LSB    = 0;

    typedef enum logic {
        A_INSTR = 1'b0,
        C_INSTR = 1'b1
    } instr_type_e;

    typedef struct packed {
        logic       a;
        logic [5:0] c;
        logic [2:0] d;
        logic [2:0] j;
    } ctrl_s;

    localparam ctrl_s CTRL_NOP = '{a: 1'b0, c: 6'b000000, d: 3'b000, j: 3'b000};

    // A C-instruction is well formed only when both don't-care bits are set.
    function automatic logic dontcare_malformed(input logic [INSTR_W-1:0] instr);
        return instr[TYPE_BIT] & (instr[DC_MSB:DC_LSB] != 2'b11);
    endfunction

endpackage

// File: rtl/hack_instr_decode_if.sv
// Decoder bus: instruction word and capture enable in, decoded fields out.
// master = fetch/consumer side, slave = the decoder.
interface hack_instr_decode_if #(
    parameter int DW = 16
);
    logic          en;
    logic [DW-1:0] instr;
    logic          instr_type;
    logic [DW-1:0] instr_v;
    logic          cmd_a;
    logic          cmd_c1;
    logic          cmd_c2;
    logic          cmd_c3;
    logic          cmd_c4;
    logic          cmd_c5;
    logic          cmd_c6;
    logic          cmd_d1;
    logic          cmd_d2;
    logic          cmd_d3;
    logic          cmd_j1;
    logic          cmd_j2;
    logic          cmd_j3;
    logic          instr_illegal;

    modport master (
        output en, instr,
        input  instr_type, instr_v, cmd_a,
        input  cmd_c1, cmd_c2, cmd_c3, cmd_c4, cmd_c5, cmd_c6,
        input  cmd_d1, cmd_d2, cmd_d3, cmd_j1, cmd_j2, cmd_j3,
        input  instr_illegal
    );

    modport slave (
        input  en, instr,
        output instr_type, instr_v, cmd_a,
        output cmd_c1, cmd_c2, cmd_c3, cmd_c4, cmd_c5, cmd_c6,
        output cmd_d1, cmd_d2, cmd_d3, cmd_j1, cmd_j2, cmd_j3,
        output instr_illegal
    );
endinterface

// File: rtl/hack_instr_decode_fields.sv
// Pure combinational field split of a Hack instruction word. A-instructions
// yield a zero-extended value and no control bits; C-instructions yield the
// control bits and a zero value. Bits 14:13 are ignored here.
module hack_instr_fields
    import hack_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output instr_type_e        type_o,
    output logic [INSTR_W-1:0] value_o,
    output ctrl_s              ctrl_o
);

    // Field decode; every output defaulted so no branch leaves an X.
    always_comb begin
        type_o  = A_INSTR;
        value_o = {INSTR_W{1'b0}};
        ctrl_o  = CTRL_NOP;
        if (instr_i[TYPE_BIT]) begin
            type_o   = C_INSTR;
            ctrl_o.a = instr_i[A_BIT];
            ctrl_o.c = instr_i[C_MSB:C_LSB];
            ctrl_o.d = instr_i[D_MSB:D_LSB];
            ctrl_o.j = instr_i[J_MSB:J_LSB];
        end else begin
            value_o = {1'b0, instr_i[TYPE_BIT-1:0]};
        end
    end

endmodule

// File: rtl/hack_instr_decode.sv
// Hack CPU instruction decoder top: combinational field split followed by
// an enable-gated output register (one cycle latency, holds when en = 0).
// Optional feature macro: INSTR_DECODE_ILLEGAL_CHK_EN -- when defined,
// instr_illegal flags C-instructions whose bits 14:13 are not 2'b11;
// otherwise instr_illegal is constant 0.
module hack_instr_decode
    import hack_pkg::*;
#(
    parameter int DW = INSTR_W
)(
    input  logic                 clk,
    input  logic                 rst_n,
    hack_instr_decode_if.slave   bus
);

    if (DW != INSTR_W) begin : g_dw_bad
        $fatal(1, "hack_instr_decode: DW must be 16");
    end

    instr_type_e        dec_type_s;
    logic [INSTR_W-1:0] dec_value_s;
    ctrl_s              dec_ctrl_s;
    logic               dec_illegal_s;

    instr_type_e        type_d,    type_q;
    logic [INSTR_W-1:0] value_d,   value_q;
    ctrl_s              ctrl_d,    ctrl_q;
    logic               illegal_d, illegal_q;

    hack_instr_fields u_fields (
        .instr_i (bus.instr),
        .type_o  (dec_type_s),
        .value_o (dec_value_s),
        .ctrl_o  (dec_ctrl_s)
    );

`ifdef INSTR_DECODE_ILLEGAL_CHK_EN
    assign dec_illegal_s = dontcare_malformed(bus.instr);
`else
    assign dec_illegal_s = 1'b0;
`endif

    // Next-state: load the fresh decode when enabled, otherwise hold.
    always_comb begin
        type_d    = type_q;
        value_d   = value_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        if (bus.en) begin
            type_d    = dec_type_s;
            value_d   = dec_value_s;
            ctrl_d    = dec_ctrl_s;
            illegal_d = dec_illegal_s;
        end else begin
            type_d    = type_q;
            value_d   = value_q;
            ctrl_d    = ctrl_q;
            illegal_d = illegal_q;
        end
    end

    // Output register; async reset clears every output and any pending capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_q    <= A_INSTR;
            value_q   <= {INSTR_W{1'b0}};
            ctrl_q    <= CTRL_NOP;
            illegal_q <= 1'b0;
        end else begin
            type_q    <= type_d;
            value_q   <= value_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.instr_type    = type_q;
    assign bus.instr_v       = value_q;
    assign bus.cmd_a         = ctrl_q.a;
    assign bus.cmd_c1        = ctrl_q.c[5];
    assign bus.cmd_c2        = ctrl_q.c[4];
    assign bus.cmd_c3        = ctrl_q.c[3];
    assign bus.cmd_c4        = ctrl_q.c[2];
    assign bus.cmd_c5        = ctrl_q.c[1];
    assign bus.cmd_c6        = ctrl_q.c[0];
    assign bus.cmd_d1        = ctrl_q.d[2];
    assign bus.cmd_d2        = ctrl_q.d[1];
    assign bus.cmd_d3        = ctrl_q.d[0];
    assign bus.cmd_j1        = ctrl_q.j[2];
    assign bus.cmd_j2        = ctrl_q.j[1];
    assign bus.cmd_j3        = ctrl_q.j[0];
    assign bus.instr_illegal = illegal_q;

endmodule

// File: tb/tb_hack_instr_decode.sv
// Directed self-checking bench for hack_instr_decode. All outputs are packed
// into one 31-bit word {type, v[15:0], a, c1..c6, d1..d3, j1..j3, illegal}
// and compared against hand-computed expectations.
module tb_hack_instr_decode;

`ifdef INSTR_DECODE_ILLEGAL_CHK_EN
    localparam logic ILL_ON = 1'b1;
`else
    localparam logic ILL_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   n_fail;

    hack_instr_decode_if #(.DW(16)) bus ();

    hack_instr_decode #(.DW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [30:0] exp_word(input logic t, input logic [15:0] v,
                                             input logic a, input logic [5:0] c,
                                             input logic [2:0] d, input logic [2:0] j,
                                             input logic ill);
        return {t, v, a, c, d, j, ill};
    endfunction

    function automatic logic [30:0] obs_word();
        return {bus.instr_type, bus.instr_v, bus.cmd_a,
                bus.cmd_c1, bus.cmd_c2, bus.cmd_c3, bus.cmd_c4, bus.cmd_c5, bus.cmd_c6,
                bus.cmd_d1, bus.cmd_d2, bus.cmd_d3,
                bus.cmd_j1, bus.cmd_j2, bus.cmd_j3, bus.instr_illegal};
    endfunction

    task automatic check(input string tag, input logic [30:0] expv);
        logic [30:0] obs;
        obs = obs_word();
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.en  = 1'b1;
        bus.instr = 16'hFFFF;

        // Reset held with enable high: nothing captured.
        step();
        step();
        check("reset_hold", exp_word(1'b0, 16'h0000, 1'b0, 6'h00, 3'h0, 3'h0, 1'b0));

        // Release away from the edge; first edge captures FFFF.
        rst_n = 1'b1;
        step();
        check("first_ffff", exp_word(1'b1, 16'h0000, 1'b1, 6'h3F, 3'h7, 3'h7, 1'b0));

        bus.instr = 16'h7FFF;
        step();
        check("a_7fff", exp_word(1'b0, 16'h7FFF, 1'b0, 6'h00, 3'h0, 3'h0, 1'b0));

        bus.instr = 16'h0000;
        step();
        check("a_0000", exp_word(1'b0, 16'h0000, 1'b0, 6'h00, 3'h0, 3'h0, 1'b0));

        bus.instr = 16'h8000;
        step();
        check("c_8000", exp_word(1'b1, 16'h0000, 1'b0, 6'h00, 3'h0, 3'h0, ILL_ON));

        bus.instr = 16'hEFD0;   // D=1
        step();
        check("d_eq_1", exp_word(1'b1, 16'h0000, 1'b0, 6'h3F, 3'h2, 3'h0, 1'b0));

        bus.instr = 16'hE090;   // D=D+A
        step();
        check("d_plus_a", exp_word(1'b1, 16'h0000, 1'b0, 6'h02, 3'h2, 3'h0, 1'b0));

        bus.instr = 16'hEDC8;   // M=A+1
        step();
        check("m_a_plus1", exp_word(1'b1, 16'h0000, 1'b0, 6'h37, 3'h1, 3'h0, 1'b0));

        bus.instr = 16'h9007;   // bits 14:13 = 00, a=1, JMP
        step();
        check("c_9007", exp_word(1'b1, 16'h0000, 1'b1, 6'h00, 3'h0, 3'h7, ILL_ON));

        bus.instr = 16'hB03F;   // bits 14:13 = 01, a=1, d=111, j=111
        step();
        check("c_b03f", exp_word(1'b1, 16'h0000, 1'b1, 6'h00, 3'h7, 3'h7, ILL_ON));

        bus.instr = 16'hE000;
        step();
        check("c_e000", exp_word(1'b1, 16'h0000, 1'b0, 6'h00, 3'h0, 3'h0, 1'b0));

        // Enable low: outputs hold E000 decode while instr changes.
        bus.en = 1'b0;
        bus.instr = 16'h7FFF;
        step();
        check("hold_1", exp_word(1'b1, 16'h0000, 1'b0, 6'h00, 3'h0, 3'h0, 1'b0));
        bus.instr = 16'hEFD0;
        step();
        check("hold_2", exp_word(1'b1, 16'h0000, 1'b0, 6'h00, 3'h0, 3'h0, 1'b0));
        bus.instr = 16'h1234;
        step();
        check("hold_3", exp_word(1'b1, 16'h0000, 1'b0, 6'h00, 3'h0, 3'h0, 1'b0));

        // Re-enable: single-cycle capture of the current word.
        bus.en = 1'b1;
        step();
        check("reen_1234", exp_word(1'b0, 16'h1234, 1'b0, 6'h00, 3'h0, 3'h0, 1'b0));

        // Mid-stream async reset clears outputs without a clock edge.
        bus.instr = 16'hEFD0;
        rst_n = 1'b0;
        #1;
        check("async_rst", exp_word(1'b0, 16'h0000, 1'b0, 6'h00, 3'h0, 3'h0, 1'b0));
        step();
        check("rst_no_cap", exp_word(1'b0, 16'h0000, 1'b0, 6'h00, 3'h0, 3'h0, 1'b0));

        rst_n = 1'b1;
        bus.instr = 16'hE090;
        step();
        check("post_rst", exp_word(1'b1, 16'h0000, 1'b0, 6'h02, 3'h2, 3'h0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
